apb_cfg_regfile: RTL

- Parametrised APB3 slave holding the configuration register bank of the ECC encoder/decoder core.
- Generalises the fixed four-register APB slave with parametric register count, programmable wait states (PREADY) and error response (PSLVERR).
- Adds a read-only status register fed by the core, a write-lock while the core is busy, and a start pulse on CTRL writes.
- Sits between the APB master and the ECC datapath.

---
 rtl/apb_cfg_regfile.sv | 134 +++++++++++++
 1 files changed

// File: rtl/apb_cfg_regfile.sv
// APB3 slave holding the ECC core configuration bank: NUM_REGS R/W registers,
// one read-only status word, programmable wait states, error response and a CTRL start pulse.
module apb_cfg_regfile #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int NUM_REGS        = 4,
    parameter int WAIT_STATES     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
    input  logic [AMBA_WORD-1:0]          PWDATA,
    output logic [AMBA_WORD-1:0]          PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    input  logic [AMBA_WORD-1:0]          direct_write,
    input  logic                          core_busy,
    output logic [NUM_REGS*AMBA_WORD-1:0] cfg_regs,
    output logic                          ctrl_start
);

    localparam int                IDX_W      = AMBA_ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0]  STATUS_IDX = IDX_W'(NUM_REGS);
    localparam logic [3:0]        WAIT_LAST  = 4'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                 state, state_next;
    logic [3:0]             cnt, cnt_next;
    logic [AMBA_WORD-1:0]   regs [NUM_REGS];
    logic [AMBA_WORD-1:0]   status;
    logic [AMBA_WORD-1:0]   rdata_sel;
    logic [IDX_W-1:0]       idx;
    logic                   ready, is_cfg, is_status, err, complete, wr_en;

    assign idx       = PADDR[AMBA_ADDR_WIDTH-1:2];
    assign is_cfg    = (idx < STATUS_IDX);
    assign is_status = (idx == STATUS_IDX);
    assign ready     = (state == ACCESS) && (cnt == WAIT_LAST);
    assign complete  = ready && PSEL && PENABLE;

    // core_busy is looked at only in the completion cycle; reads are never locked.
    assign err = (PADDR[1:0] != 2'b00)
              || (idx > STATUS_IDX)
              || (PWRITE && is_status)
              || (PWRITE && is_cfg && core_busy);

    assign wr_en = complete && PWRITE && !err;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        PREADY     = ready;
        PSLVERR    = 1'b0;
        PRDATA     = '0;
        unique case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_next = ACCESS;
                    cnt_next   = '0;
                end
            end
            ACCESS: begin
                // Dropping PSEL or PENABLE before PREADY is an abort, not a transfer.
                if (!PSEL || !PENABLE || ready) begin
                    state_next = IDLE;
                end else if (cnt < WAIT_LAST) begin
                    cnt_next = cnt + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (ready) begin
            PSLVERR = err;
            if (!PWRITE && !err) begin
                PRDATA = rdata_sel;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ctrl_start <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            ctrl_start <= wr_en && (idx == '0);
        end
    end

    // NOTE: the register bank is reset because software reads it back as a known configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            status <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            status <= direct_write;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && (idx == IDX_W'(i))) begin
                    regs[i] <= PWDATA;
                end
            end
        end
    end

    always_comb begin
        rdata_sel = '0;
        if (is_status) begin
            rdata_sel = status;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                rdata_sel = regs[i];
            end
        end
    end

    always_comb begin
        cfg_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cfg_regs[i*AMBA_WORD +: AMBA_WORD] = regs[i];
        end
    end

endmodule
